neuron_q_collector: RTL and testbench
=====================================

// Module: neuron_q_collector
// PURPOSE
//   Downstream capture stage for the digital neuron output Q (8b, updates once per CK1 period).
//   - Samples Q when the neuron flags it valid.
//   - Tags each sample with a wrapping sequence number.
//   - Buffers samples in a small first-word-fall-through FIFO.
//   - Hands samples to the consumer (readout/monitor) over a valid/ready handshake.
//   - Counts samples lost to back-pressure so the bench can tell stalls from neuron errors.
// PARAMETERS
//   WIDTH = 8  : neuron output width (Q_IN/Q_OUT bits)
//   DEPTH = 4  : FIFO entries; power of 2, >= 2
//   SEQW  = 8  : sequence-tag and drop-counter width
// PORTS
//   CK1       input   1             sole clock, rising edge; 100 MHz neuron sample clock
//   RST       input   1             asynchronous, active-high reset
//   Q_IN      input   WIDTH         neuron output sample
//   Q_VLD     input   1             Q_IN valid this cycle
//   Q_OUT     output  WIDTH         head-of-FIFO sample
//   SEQ_OUT   output  SEQW          sequence tag of head sample
//   OUT_VLD   output  1             head entry valid
//   OUT_RDY   input   1             consumer accepts head this cycle
//   LEVEL     output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
//   DROP_CNT  output  SEQW          dropped-sample count, saturating
//   OVF       output  1             sticky: >=1 sample dropped since reset
// BEHAVIOUR
//   Reset (async assert, sync release)
//     - Q_OUT, SEQ_OUT, DROP_CNT, LEVEL = 0; OUT_VLD = 0; OVF = 0.
//     - Internal seq counter = 0; rd/wr pointers = 0.
//     - Reset mid-operation discards all entries immediately; no handshake completes that cycle.
//   Sequence tag
//     - Internal counter increments on every cycle with Q_VLD = 1, whether the sample is
//       accepted or dropped; it wraps 2^SEQW-1 -> 0.
//     - An accepted sample carries the counter value before the increment (first sample = 0).
//     - Gaps in SEQ_OUT therefore identify drops.
//   Pop
//     - pop = OUT_VLD && OUT_RDY.
//   Push
//     - push = Q_VLD && (LEVEL < DEPTH || pop).
//     - When full, a push and pop in the same cycle are both allowed: LEVEL holds at DEPTH.
//   Drop
//     - drop = Q_VLD && LEVEL == DEPTH && !pop.
//     - On a drop: DROP_CNT += 1, saturating at all-ones; OVF <= 1 and stays 1 until RST.
//   Latency
//     - A sample pushed at edge N is visible at OUT_VLD/Q_OUT/SEQ_OUT after edge N, when the
//       FIFO was empty. There is no combinational path from Q_IN to Q_OUT.
//   Empty
//     - OUT_VLD = 0. Q_OUT and SEQ_OUT hold their last popped values (not X).
//     - Push and pop together on empty: push only (pop cannot occur since OUT_VLD = 0).
//   Output stability
//     - While OUT_VLD = 1 and OUT_RDY = 0, Q_OUT and SEQ_OUT hold stable.
//   Occupancy
//     - LEVEL changes +1 on push-only, -1 on pop-only, 0 on both or neither.
//   Pointers
//     - $clog2(DEPTH) bits plus a wrap bit; full/empty are derived from the pointers.
//     - The pointers must wrap cleanly past DEPTH-1.
//   Outputs
//     - All outputs are registered or decoded directly from registers.
// STRUCTURE
//   - Package neuron_pkg:
//       localparam NEURON_W = 8;
//       typedef logic [NEURON_W-1:0] q_t;
//       typedef struct packed { q_t q; logic [7:0] seq; } q_entry_t;
//   - Sub-module neuron_q_fifo_mem:
//       DEPTH x q_entry_t register array; write port (we, waddr, wdata) and async read port.
//       No reset on the storage array.
//   - Top: control logic, covering pointers, level, seq counter, drop counter and OVF.
// TESTING
//   - Reset: assert RST mid-stream with 3 entries stored -> all outputs 0 on the same edge
//     (async); after release, first push gets SEQ_OUT = 0.
//   - Pass-through: OUT_RDY = 1, Q_VLD = 1 with Q_IN = 8'hA5, 8'h3C, 8'hFF on consecutive
//     cycles -> Q_OUT shows the same values one cycle later, SEQ_OUT = 0, 1, 2, LEVEL <= 1,
//     DROP_CNT = 0.
//   - Fill/overflow: OUT_RDY = 0, push 6 samples into DEPTH = 4 -> LEVEL = 4, DROP_CNT = 2,
//     OVF = 1; then drain -> SEQ_OUT = 0, 1, 2, 3 and OUT_VLD falls after the 4th pop.
//   - Full with simultaneous push/pop: LEVEL = 4, Q_VLD = 1 and OUT_RDY = 1 for 10 cycles ->
//     LEVEL stays 4, DROP_CNT is unchanged, SEQ_OUT is contiguous.
//   - Saturation/wrap (SEQW = 8): 300 drops -> DROP_CNT = 8'hFF and holds; 256 accepted
//     samples -> SEQ_OUT wraps 8'hFF -> 8'h00.
//   - Co-simulation: chain neuron_ref -> collector with random Q and random OUT_RDY (50%) ->
//     popped Q_OUT stream equals the neuron_ref Q stream minus the dropped SEQ indices;
//     zero mismatches reported at final.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared types for the neuron Q capture path: sample type and tagged FIFO entry.
package neuron_pkg;

  localparam int NEURON_W = 8;

  typedef logic [NEURON_W-1:0] q_t;

  typedef struct packed {
    q_t         q;
    logic [7:0] seq;
  } q_entry_t;

endpackage

// File: rtl/neuron_q_fifo_mem.sv
// Storage array for the collector FIFO: one synchronous write port, one asynchronous read port.
module neuron_q_fifo_mem
  import neuron_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int EW    = $bits(q_entry_t)
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [EW-1:0]            i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [EW-1:0]            o_rdata
);

  // No reset: entries are only ever read after being written.
  logic [EW-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/neuron_q_collector.sv
// Captures valid neuron Q samples, tags them with a sequence number and hands them out
// through a first-word-fall-through FIFO, counting samples lost to back-pressure.
module neuron_q_collector
  import neuron_pkg::*;
#(
  parameter int WIDTH = NEURON_W,
  parameter int DEPTH = 4,
  parameter int SEQW  = 8
) (
  input  logic                     CK1,
  input  logic                     RST,
  input  logic [WIDTH-1:0]         Q_IN,
  input  logic                     Q_VLD,
  output logic [WIDTH-1:0]         Q_OUT,
  output logic [SEQW-1:0]          SEQ_OUT,
  output logic                     OUT_VLD,
  input  logic                     OUT_RDY,
  output logic [$clog2(DEPTH):0]   LEVEL,
  output logic [SEQW-1:0]          DROP_CNT,
  output logic                     OVF
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = WIDTH + SEQW;
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic [SEQW-1:0]   r_seq;
  logic [SEQW-1:0]   r_drop;
  logic              r_ovf;
  logic [WIDTH-1:0]  r_q_out;
  logic [SEQW-1:0]   r_seq_out;

  logic [AW:0]       w_level;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [AW:0]       w_wr_ptr_next;
  logic [AW:0]       w_rd_ptr_next;
  logic [EW-1:0]     w_wdata;
  logic [EW-1:0]     w_rdata;
  logic [EW-1:0]     w_head_next;
  logic              w_head_load;

  assign w_level = r_wr_ptr - r_rd_ptr;
  assign w_empty = (w_level == '0);
  assign w_full  = (w_level == LVL_FULL);

  assign w_pop  = !w_empty && OUT_RDY;
  assign w_push = Q_VLD && (!w_full || w_pop);
  assign w_drop = Q_VLD && w_full && !w_pop;

  assign w_wr_ptr_next = r_wr_ptr + {{AW{1'b0}}, w_push};
  assign w_rd_ptr_next = r_rd_ptr + {{AW{1'b0}}, w_pop};
  assign w_wdata       = {Q_IN, r_seq};

  neuron_q_fifo_mem #(
    .DEPTH (DEPTH),
    .EW    (EW)
  ) u_mem (
    .i_clk   (CK1),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (w_wdata),
    .i_raddr (w_rd_ptr_next[AW-1:0]),
    .o_rdata (w_rdata)
  );

  // The output register is preloaded with the next head; when that head is the entry
  // being written this cycle it is taken straight from the write data.
  assign w_head_next = (w_push && (w_rd_ptr_next == r_wr_ptr)) ? w_wdata : w_rdata;
  assign w_head_load = (w_wr_ptr_next != w_rd_ptr_next);

  always_ff @(posedge CK1 or posedge RST) begin
    if (RST) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_seq     <= '0;
      r_drop    <= '0;
      r_ovf     <= 1'b0;
      r_q_out   <= '0;
      r_seq_out <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_next;
      r_rd_ptr <= w_rd_ptr_next;
      if (Q_VLD) begin
        r_seq <= r_seq + SEQW'(1);
      end
      if (w_drop) begin
        if (r_drop != '1) begin
          r_drop <= r_drop + SEQW'(1);
        end
        r_ovf <= 1'b1;
      end
      if (w_head_load) begin
        {r_q_out, r_seq_out} <= w_head_next;
      end
    end
  end

  assign Q_OUT    = r_q_out;
  assign SEQ_OUT  = r_seq_out;
  assign OUT_VLD  = !w_empty;
  assign LEVEL    = w_level;
  assign DROP_CNT = r_drop;
  assign OVF      = r_ovf;

endmodule

// File: tb/tb_neuron_q_collector.sv
// Scoreboard bench for neuron_q_collector: a behavioural occupancy model predicts
// accept/drop per cycle and queues tagged samples that are checked as they pop.
module tb_neuron_q_collector;
  import neuron_pkg::*;

  logic       CK1 = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] Q_IN = '0;
  logic       Q_VLD = 1'b0;
  logic [7:0] Q_OUT;
  logic [7:0] SEQ_OUT;
  logic       OUT_VLD;
  logic       OUT_RDY = 1'b0;
  logic [2:0] LEVEL;
  logic [7:0] DROP_CNT;
  logic       OVF;

  int total = 0;
  int bad   = 0;

  q_entry_t   sb[$];
  q_entry_t   m_last;
  int         m_lvl;
  logic [7:0] m_seq;
  logic [7:0] m_drop;
  logic       m_ovf;

  neuron_q_collector dut (
    .CK1      (CK1),
    .RST      (RST),
    .Q_IN     (Q_IN),
    .Q_VLD    (Q_VLD),
    .Q_OUT    (Q_OUT),
    .SEQ_OUT  (SEQ_OUT),
    .OUT_VLD  (OUT_VLD),
    .OUT_RDY  (OUT_RDY),
    .LEVEL    (LEVEL),
    .DROP_CNT (DROP_CNT),
    .OVF      (OVF)
  );

  always #5 CK1 = ~CK1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_last = '0;
    m_lvl  = 0;
    m_seq  = '0;
    m_drop = '0;
    m_ovf  = 1'b0;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step(input logic vld, input logic [7:0] q, input logic rdy);
    logic pop, push, drop;
    q_entry_t e;
    @(negedge CK1);
    Q_VLD = vld;
    Q_IN = q;
    OUT_RDY = rdy;
    #1;
    chk("out_vld", 32'(OUT_VLD), 32'(m_lvl != 0));
    chk("level", 32'(LEVEL), 32'(m_lvl));
    chk("drop_cnt", 32'(DROP_CNT), 32'(m_drop));
    chk("ovf", 32'(OVF), 32'(m_ovf));
    if (m_lvl != 0) begin
      chk("q_head", 32'(Q_OUT), 32'(sb[0].q));
      chk("seq_head", 32'(SEQ_OUT), 32'(sb[0].seq));
    end else begin
      chk("q_hold", 32'(Q_OUT), 32'(m_last.q));
      chk("seq_hold", 32'(SEQ_OUT), 32'(m_last.seq));
    end
    pop  = (m_lvl != 0) && rdy;
    push = vld && ((m_lvl < 4) || pop);
    drop = vld && !push;
    if (pop) begin
      m_last = sb.pop_front();
      $display("pop  q=%02h seq=%0d", m_last.q, m_last.seq);
    end
    if (push) begin
      e.q = q;
      e.seq = m_seq;
      sb.push_back(e);
    end
    if (drop) begin
      if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
      m_ovf = 1'b1;
      $display("drop q=%02h seq=%0d", q, m_seq);
    end
    if (vld) m_seq = m_seq + 8'd1;
    m_lvl = m_lvl + (push ? 1 : 0) - (pop ? 1 : 0);
    @(posedge CK1);
  endtask

  initial begin
    logic [7:0] pt[3];
    model_reset();
    repeat (2) @(posedge CK1);
    @(negedge CK1);
    RST = 1'b0;
    step(1'b0, 8'h00, 1'b0);

    // Pass-through
    pt[0] = 8'hA5; pt[1] = 8'h3C; pt[2] = 8'hFF;
    for (int i = 0; i < 3; i++) step(1'b1, pt[i], 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("pt_last_q", 32'(Q_OUT), 32'hFF);
    chk("pt_last_seq", 32'(SEQ_OUT), 32'd2);

    // Asynchronous reset with 3 entries stored
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    @(negedge CK1);
    Q_VLD = 1'b0;
    OUT_RDY = 1'b0;
    chk("pre_rst_level", 32'(LEVEL), 32'd3);
    #2 RST = 1'b1;
    #1;
    chk("rst_q", 32'(Q_OUT), 32'd0);
    chk("rst_seq", 32'(SEQ_OUT), 32'd0);
    chk("rst_vld", 32'(OUT_VLD), 32'd0);
    chk("rst_level", 32'(LEVEL), 32'd0);
    model_reset();
    @(negedge CK1);
    RST = 1'b0;
    @(posedge CK1);
    step(1'b1, 8'h77, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("post_rst_seq", 32'(m_last.seq), 32'd0);

    // Fill / overflow then drain
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("fill_level", 32'(LEVEL), 32'd4);
    chk("fill_drop", 32'(DROP_CNT), 32'd2);
    chk("fill_ovf", 32'(OVF), 32'd1);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1);
    chk("drain_vld", 32'(OUT_VLD), 32'd0);

    // Full with simultaneous push and pop
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h80 + i), 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h90 + i), 1'b1);
    step(1'b0, 8'h00, 1'b0);
    chk("full_pp_level", 32'(LEVEL), 32'd4);
    chk("full_pp_drop", 32'(DROP_CNT), 32'd2);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1);

    // Drop-counter saturation
    for (int i = 0; i < 304; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("drop_sat", 32'(DROP_CNT), 32'hFF);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1);

    // Sequence wrap over many accepted samples
    for (int i = 0; i < 300; i++) step(1'b1, 8'(i * 7), 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);

    // Random source against random back-pressure
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 1) == 1);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("final_drop", 32'(DROP_CNT), 32'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
